// File: rtl/pc_sequencer.sv
// Multi-cycle program-counter sequencer: fetches over a req/ack handshake,
// holds the instruction through execute, then applies the branch decision.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [15:0] retire_count,
  output logic        halted,
  output logic        fetch_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    HALT,
    ERROR
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state;
  logic [7:0]  wait_count;

  // HALT and ERROR are terminal: only reset brings the sequencer back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      instr        <= 32'h0000_0000;
      retire_count <= 16'h0000;
      wait_count   <= 8'h00;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            instr      <= imem_rdata;
            wait_count <= 8'h00;
            state      <= EXEC;
          end else begin
            wait_count <= wait_count + 8'd1;
            if (wait_count == WAIT_LAST) state <= ERROR;
          end
        end
        EXEC: begin
          if (exec_done) begin
            if (halt) begin
              state <= HALT;
            end else begin
              pc           <= branch_taken ? (branch_target & 32'hFFFF_FFFC)
                                           : pc + 32'd4;
              retire_count <= retire_count + 16'd1;
              state        <= FETCH;
            end
          end
        end
        default: state <= state;
      endcase
    end
  end

  assign imem_req      = (state == FETCH);
  assign imem_addr     = pc;
  assign instr_valid   = (state == EXEC);
  assign halted        = (state == HALT);
  assign fetch_timeout = (state == ERROR);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random traffic, all
// compared each cycle against a behavioural model of fetch/execute/retire.
module tb_pc_sequencer;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        exec_done = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        halt = 1'b0;

  logic        imem_req, instr_valid, halted, fetch_timeout;
  logic [31:0] imem_addr, instr, pc;
  logic [15:0] retire_count;

  logic        d2_imem_req, d2_instr_valid, d2_halted, d2_fetch_timeout;
  logic [31:0] d2_imem_addr, d2_instr, d2_pc;
  logic [15:0] d2_retire_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0 idle, 1 fetching, 2 executing, 3 halted, 4 timed out
  int          m_phase;
  int          m_misses;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  int          m_retired;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .exec_done(exec_done), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt(halt),
    .pc(pc), .retire_count(retire_count),
    .halted(halted), .fetch_timeout(fetch_timeout)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(16)) dut2 (
    .clk(clk), .reset(reset),
    .imem_req(d2_imem_req), .imem_addr(d2_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(d2_instr), .instr_valid(d2_instr_valid),
    .exec_done(exec_done), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt(halt),
    .pc(d2_pc), .retire_count(d2_retire_count),
    .halted(d2_halted), .fetch_timeout(d2_fetch_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_misses  = 0;
    m_pc      = 32'h0000_0000;
    m_instr   = 32'h0000_0000;
    m_retired = 0;
  endtask

  task automatic model_step();
    case (m_phase)
      0: m_phase = 1;
      1: begin
        if (imem_ack) begin
          m_instr  = imem_rdata;
          m_misses = 0;
          m_phase  = 2;
        end else begin
          m_misses++;
          if (m_misses == MW) m_phase = 4;
        end
      end
      2: begin
        if (exec_done) begin
          if (halt) begin
            m_phase = 3;
          end else begin
            if (branch_taken) m_pc = {branch_target[31:2], 2'b00};
            else              m_pc = m_pc + 32'd4;
            m_retired = (m_retired + 1) % 65536;
            m_phase   = 1;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic checkOutput();
    chk("imem_req", 32'(imem_req), 32'(m_phase == 1));
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("instr", instr, m_instr);
    chk("instr_valid", 32'(instr_valid), 32'(m_phase == 2));
    chk("retire_count", 32'(retire_count), 32'(m_retired));
    chk("halted", 32'(halted), 32'(m_phase == 3));
    chk("fetch_timeout", 32'(fetch_timeout), 32'(m_phase == 4));
  endtask

  // Advance one clock, update the model with the inputs seen at the edge, then check.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    checkOutput();
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    #1;
    model_reset();
    checkOutput();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic ack, input logic done, input logic br,
                               input logic [31:0] tgt, input logic hlt);
    imem_ack      = ack;
    imem_rdata    = $urandom;
    exec_done     = done;
    branch_taken  = br;
    branch_target = tgt;
    halt          = hlt;
  endtask

  initial begin
    #2;
    model_reset();
    checkOutput();
    @(negedge clk);
    reset = 1'b0;

    // Sequential execution with zero-wait memory
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int t = 1; t <= 9; t++) begin
      tick();
      if (t % 2 == 1) chk("seq_addr", imem_addr, 32'((t - 1) * 2));
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    end
    chk("seq_retire4", 32'(retire_count), 32'd4);

    // Taken branch from 0x10 drops the target's low bits
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
    tick();
    chk("branch_addr", imem_addr, 32'h0000_0100);
    chk("branch_retire", 32'(retire_count), 32'd5);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0020, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0020, 1'b0);
    tick();
    chk("branch2_addr", imem_addr, 32'h0000_0020);

    // Halt beats branch and then everything is ignored
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0400, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0400, 1'b1);
    tick();
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", pc, 32'h0000_0020);
    chk("halt_retire", 32'(retire_count), 32'd6);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
      tick();
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_hold_pc", pc, 32'h0000_0020);
    end

    // Timeout after MW unanswered fetch cycles
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    pulseReset();
    tick();
    for (int i = 1; i <= MW; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      chk("timeout_flag", 32'(fetch_timeout), 32'(i == MW));
    end

    // Ack in the last allowed cycle is accepted
    pulseReset();
    tick();
    for (int i = 1; i < MW; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("late_ack_valid", 32'(instr_valid), 32'd1);
    chk("late_ack_timeout", 32'(fetch_timeout), 32'd0);

    // Second instance resets to the top of memory and wraps to zero
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    pulseReset();
    chk("d2_reset_pc", d2_pc, 32'hFFFF_FFFC);
    chk("d2_reset_instr", d2_instr, 32'h0);
    chk("d2_reset_retire", 32'(d2_retire_count), 32'd0);
    chk("d2_reset_flags", {28'h0, d2_imem_req, d2_instr_valid, d2_halted, d2_fetch_timeout}, 32'h0);
    tick();
    chk("d2_first_addr", d2_imem_addr, 32'hFFFF_FFFC);
    chk("d2_first_req", 32'(d2_imem_req), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    chk("d2_wrap_addr", d2_imem_addr, 32'h0000_0000);
    chk("d2_wrap_retire", 32'(d2_retire_count), 32'd1);

    // Reset lands in EXEC while exec_done is high: no retire, no pc update
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    chk("pre_reset_exec", 32'(instr_valid), 32'd1);
    pulseReset();
    chk("mid_reset_pc", pc, 32'h0000_0000);
    chk("mid_reset_retire", 32'(retire_count), 32'd0);
    chk("mid_reset_idle_req", 32'(imem_req), 32'd0);
    tick();
    chk("after_reset_req", 32'(imem_req), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom),
                    $urandom, $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) pulseReset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
